fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO word and stream data.
REQ-002 Parameter PKT_LEN, default 16, beats per packet; legal range 1..65535.
REQ-003 Parameter CNT_WIDTH, default 16, width of beat and packet counters.
REQ-004 clk  in  1  clock; all logic SHALL be clocked on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  synchronous discard of buffered/in-flight data and the packet beat count.
REQ-007 fifo_empty  in  1  empty flag of the upstream synchronous FIFO.
REQ-008 fifo_dout  in  DATA_WIDTH  registered FIFO read data, valid the cycle after an accepted read.
REQ-009 fifo_rd_en  out  1  FIFO read request.
REQ-010 m_valid  out  1  stream data valid.
REQ-011 m_ready  in  1  downstream accept.
REQ-012 m_data  out  DATA_WIDTH  stream data.
REQ-013 m_last  out  1  final beat of a packet.
REQ-014 pkt_count  out  CNT_WIDTH  completed packets, modulo 2^CNT_WIDTH.

Function
REQ-015 The block SHALL contain a 3-entry in-order output buffer (occ 0..3) plus a 1-bit in_flight flag.
REQ-016 fifo_rd_en SHALL equal !fifo_empty && !flush && !rst && (occ + in_flight <= 2), with no combinational path from m_ready.
REQ-017 in_flight SHALL be set on the cycle after fifo_rd_en=1 and cleared otherwise.
REQ-018 When in_flight=1, fifo_dout SHALL be pushed into the buffer at that clock edge, unless flush=1.
REQ-019 First-word latency: m_valid SHALL rise 2 clock edges after the edge at which fifo_rd_en=1 is sampled, with buffer empty.
REQ-020 m_valid SHALL equal (occ != 0); m_data SHALL be the buffer head.
REQ-021 A handshake (m_valid && m_ready) SHALL pop the head; simultaneous push and pop SHALL leave occ unchanged.
REQ-022 Once m_valid=1, m_data and m_last SHALL stay stable until the handshake.
REQ-023 With fifo_empty=0 and m_ready=1 held, throughput SHALL be 1 beat per cycle after the initial latency.
REQ-024 beat_cnt SHALL increment per handshake and wrap to 0 after the handshake with beat_cnt = PKT_LEN-1.
REQ-025 m_last SHALL equal m_valid && (beat_cnt == PKT_LEN-1); PKT_LEN=1 SHALL assert m_last on every beat.
REQ-026 pkt_count SHALL increment on each handshake with m_last=1 and wrap from 2^CNT_WIDTH-1 to 0.
REQ-027 flush=1 SHALL clear occ, in_flight and beat_cnt at that edge, discard any returning word, and leave pkt_count unchanged.
REQ-028 A handshake coinciding with flush SHALL complete for the beat presented, but SHALL NOT increment pkt_count.
REQ-029 The buffer SHALL never overflow; a push with occ=3 is unreachable by REQ-016 and SHALL be flagged by an assertion.

Reset
REQ-030 rst SHALL take priority over flush and all other inputs.
REQ-031 On rst, occ, in_flight, beat_cnt and pkt_count SHALL be 0, and m_valid, m_last and fifo_rd_en SHALL be 0.
REQ-032 Buffer storage and m_data need not be reset; m_data is don't-care while m_valid=0.
REQ-033 If rst is asserted mid-packet, the next packet after reset SHALL start at beat 0.

Structure
REQ-034 DATA_WIDTH and CNT_WIDTH defaults SHALL live in shared package fifo_pkg, also used by the FIFO.
REQ-035 The 3-entry buffer SHALL be a sub-module stream_buf3 with push, pop, data, occ and flush ports.
REQ-036 The counter and rd_en logic SHALL stay in fifo_rd_stream; the RTL target is 120-400 lines.

Verification
REQ-037 Basic latency: FIFO preloaded with 0x01..0x10, m_ready=1 -> m_valid rises 2 edges after the first fifo_rd_en, 16 consecutive beats 0x01..0x10, m_last on 0x10, pkt_count=1.
REQ-038 Backpressure: m_ready toggles 1,0,0,1 with a 40-word FIFO -> no loss, duplication or reordering; fifo_rd_en never asserted when occ+in_flight=3; data stable while stalled.
REQ-039 Empty gaps: fifo_empty pulses high for 3 cycles mid-packet -> m_valid drops, and m_last still marks beat 16 of the packet.
REQ-040 Flush mid-flight: flush asserted the cycle after fifo_rd_en, with occ=2 -> next cycle m_valid=0, returning word dropped, next beat has beat_cnt 0, pkt_count unchanged.
REQ-041 Counter wrap: PKT_LEN=1 and CNT_WIDTH=4, 17 beats -> m_last on every beat, pkt_count reads 0 after beat 16 and 1 after beat 17.
REQ-042 Reset mid-packet: rst asserted after beat 5 -> all outputs 0 next cycle; a subsequent 16-word packet asserts m_last only on beat 16.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the upstream synchronous FIFO and the stream reader that drains it.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int BUF_DEPTH      = 3;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read side plus valid/ready stream side of the FIFO-to-stream adapter.
interface fifo_rd_stream_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/fifo_rd_stream_buf3.sv
// Three-entry in-order circular buffer; head word is always presented on data.
module stream_buf3 import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic                  do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign do_pop = pop && (occ != 2'd0);
    assign data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && occ == 2'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-output synchronous FIFO into a packetised valid/ready stream.
module fifo_rd_stream import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    logic                 in_flight;
    occ_t                 occ;
    logic [2:0]           pending;
    logic                 push;
    logic                 pop;
    logic [CNT_WIDTH-1:0] beat_cnt;

    // Reserve a slot for every word already requested so the buffer cannot overflow.
    assign pending        = {1'b0, occ} + {2'b00, in_flight};
    assign bus.fifo_rd_en = !bus.fifo_empty && !flush && !rst && (pending <= 3'd2);

    assign push        = in_flight && !flush;
    assign bus.m_valid = (occ != 2'd0);
    assign pop         = bus.m_valid && bus.m_ready;
    assign bus.m_last  = bus.m_valid && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) in_flight <= 1'b0;
        else     in_flight <= bus.fifo_rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) beat_cnt <= '0;
        else if (pop)     beat_cnt <= bus.m_last ? '0 : beat_cnt + 1'b1;
    end

    // A final beat taken during flush still leaves the packet count alone.
    always_ff @(posedge clk) begin
        if (rst)                              pkt_count <= '0;
        else if (pop && bus.m_last && !flush) pkt_count <= pkt_count + 1'b1;
    end

    stream_buf3 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .data      (bus.m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: an upstream FIFO model feeds the expected queue, a monitor checks the stream.
module tb_fifo_rd_stream;

    localparam int PKT_A = 16;

    logic clk;
    logic rst_a, flush_a, gap_a;
    logic rst_b, flush_b;
    logic [15:0] pkt_count_a;
    logic [3:0]  pkt_count_b;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) ifa ();
    fifo_rd_stream_if #(.DATA_WIDTH(8)) ifb ();

    fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(PKT_A), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a), .bus(ifa), .pkt_count(pkt_count_a));

    fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b), .bus(ifb), .pkt_count(pkt_count_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    // Upstream FIFO contents: the bench appends, the FIFO model consumes.
    logic [7:0] src_a [1024];
    logic [7:0] src_b [64];
    int loaded_a = 0, read_a = 0;
    int loaded_b = 0, read_b = 0;
    logic inflight_a = 1'b0, inflight_b = 1'b0;

    assign ifa.fifo_empty = gap_a || (read_a == loaded_a);
    assign ifb.fifo_empty = (read_b == loaded_b);

    // Reference: the stream is the FIFO order, minus words lost to flush or reset.
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int   beat_m = 0;
    logic [15:0] pkt_m = '0;
    logic [3:0]  pkt_b = '0;
    int   hs_a = 0, hs_b = 0;
    logic rst_prev_a = 1'b0;
    logic stall_a = 1'b0;
    logic [7:0] stall_d = '0;
    logic stall_l = 1'b0;

    always begin
        int   buffered;
        logic last;
        @(posedge clk);
        // FIFO models: registered read data; reset empties the upstream FIFO too.
        if (rst_a) read_a <= loaded_a;
        else if (ifa.fifo_rd_en && read_a != loaded_a) begin
            ifa.fifo_dout <= src_a[read_a];
            exp_a.push_back(src_a[read_a]);
            read_a <= read_a + 1;
        end
        inflight_a <= !rst_a && ifa.fifo_rd_en && (read_a != loaded_a);
        if (rst_b) read_b <= loaded_b;
        else if (ifb.fifo_rd_en && read_b != loaded_b) begin
            ifb.fifo_dout <= src_b[read_b];
            exp_b.push_back(src_b[read_b]);
            read_b <= read_b + 1;
        end
        inflight_b <= !rst_b && ifb.fifo_rd_en && (read_b != loaded_b);

        @(negedge clk);
        if (rst_a) begin
            if (rst_prev_a) begin
                chk("rst_m_valid", 32'(ifa.m_valid), 32'(0));
                chk("rst_m_last", 32'(ifa.m_last), 32'(0));
                chk("rst_rd_en", 32'(ifa.fifo_rd_en), 32'(0));
                chk("rst_pkt_count", 32'(pkt_count_a), 32'(0));
            end
            exp_a.delete();
            beat_m = 0;
            pkt_m = '0;
            stall_a = 1'b0;
        end else begin
            buffered = exp_a.size() - int'(inflight_a);
            chk("rd_en", 32'(ifa.fifo_rd_en),
                32'(!ifa.fifo_empty && !flush_a && exp_a.size() <= 2));
            chk("m_valid", 32'(ifa.m_valid), 32'(buffered > 0));
            chk("m_last", 32'(ifa.m_last), 32'(buffered > 0 && beat_m == PKT_A - 1));
            chk("pkt_count", 32'(pkt_count_a), 32'(pkt_m));
            if (stall_a) begin
                chk("stall_data", 32'(ifa.m_data), 32'(stall_d));
                chk("stall_last", 32'(ifa.m_last), 32'(stall_l));
            end
            if (ifa.m_valid && ifa.m_ready) begin
                if (exp_a.size() == 0) chk("data_extra", 32'(exp_a.size()), 32'(1));
                else chk("data", 32'(ifa.m_data), 32'(exp_a.pop_front()));
                last = (beat_m == PKT_A - 1);
                beat_m = last ? 0 : beat_m + 1;
                if (last && !flush_a) pkt_m = pkt_m + 16'd1;
                hs_a++;
            end
            stall_a = ifa.m_valid && !ifa.m_ready && !flush_a;
            stall_d = ifa.m_data;
            stall_l = ifa.m_last;
            if (flush_a) begin
                exp_a.delete();
                beat_m = 0;
            end
        end
        rst_prev_a = rst_a;

        if (rst_b) begin
            exp_b.delete();
            pkt_b = '0;
        end else begin
            chk("b_pkt_count", 32'(pkt_count_b), 32'(pkt_b));
            if (ifb.m_valid && ifb.m_ready) begin
                chk("b_m_last", 32'(ifb.m_last), 32'(1));
                if (exp_b.size() == 0) chk("b_data_extra", 32'(exp_b.size()), 32'(1));
                else chk("b_data", 32'(ifb.m_data), 32'(exp_b.pop_front()));
                pkt_b = pkt_b + 4'd1;
                hs_b++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_a(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) begin
            src_a[loaded_a] = rnd ? 8'($urandom) : 8'(base + i);
            loaded_a++;
        end
    endtask

    task automatic drain_a(input string nm, input int limit);
        int k = 0;
        while ((read_a != loaded_a || exp_a.size() != 0) && k < limit) begin
            cyc(1);
            k++;
        end
        chk(nm, 32'((loaded_a - read_a) + exp_a.size()), 32'(0));
    endtask

    initial begin
        int k;
        int base;
        logic [15:0] saved_pkt;
        logic [3:0]  pat;
        rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0; gap_a = 1'b0;
        ifa.m_ready = 1'b0; ifb.m_ready = 1'b0;
        cyc(3);

        // First-word latency and a clean 16-beat packet.
        ifa.m_ready = 1'b1;
        rst_a = 1'b0;
        load_a(16, 1'b0, 1);
        @(negedge clk);
        chk("first_rd_en", 32'(ifa.fifo_rd_en), 32'(1));
        @(negedge clk);
        chk("latency_edge1", 32'(ifa.m_valid), 32'(0));
        @(negedge clk);
        chk("latency_edge2", 32'(ifa.m_valid), 32'(1));
        chk("first_data", 32'(ifa.m_data), 32'(8'h01));
        cyc(1);
        drain_a("drain_basic", 60);
        chk("pkt_basic", 32'(pkt_count_a), 32'(1));

        // Backpressure with ready pattern 1,0,0,1.
        pat = 4'b1001;
        load_a(40, 1'b1, 0);
        k = 0;
        while ((read_a != loaded_a || exp_a.size() != 0) && k < 400) begin
            ifa.m_ready = pat[k % 4];
            cyc(1);
            k++;
        end
        chk("drain_backpressure", 32'((loaded_a - read_a) + exp_a.size()), 32'(0));
        ifa.m_ready = 1'b1;
        flush_a = 1'b1;
        cyc(1);
        flush_a = 1'b0;

        // Empty gap of three cycles in the middle of a packet.
        load_a(16, 1'b1, 0);
        cyc(5);
        gap_a = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("gap_m_valid", 32'(ifa.m_valid), 32'(0));
        cyc(1);
        gap_a = 1'b0;
        drain_a("drain_gap", 60);

        // Flush with two buffered words and one returning.
        ifa.m_ready = 1'b0;
        load_a(20, 1'b1, 0);
        k = 0;
        while (!(exp_a.size() == 3 && inflight_a) && k < 20) begin
            cyc(1);
            k++;
        end
        chk("flush_setup", 32'(exp_a.size()), 32'(3));
        saved_pkt = pkt_count_a;
        flush_a = 1'b1;
        cyc(1);
        flush_a = 1'b0;
        @(negedge clk);
        chk("flush_m_valid", 32'(ifa.m_valid), 32'(0));
        chk("flush_pkt", 32'(pkt_count_a), 32'(saved_pkt));
        ifa.m_ready = 1'b1;
        cyc(1);
        drain_a("drain_flush", 100);

        // Random traffic, gaps, backpressure and flushes.
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0 && (loaded_a - read_a) < 8) load_a(1, 1'b1, 0);
            gap_a = ($urandom_range(0, 7) == 0);
            flush_a = ($urandom_range(0, 24) == 0);
            ifa.m_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        gap_a = 1'b0;
        flush_a = 1'b0;
        ifa.m_ready = 1'b1;
        drain_a("drain_random", 200);

        // Reset in the middle of a packet, then a fresh packet.
        load_a(16, 1'b1, 0);
        base = hs_a;
        k = 0;
        while (hs_a < base + 5 && k < 50) begin
            cyc(1);
            k++;
        end
        rst_a = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("rst_mid_valid", 32'(ifa.m_valid), 32'(0));
        chk("rst_mid_pkt", 32'(pkt_count_a), 32'(0));
        cyc(1);
        rst_a = 1'b0;
        load_a(16, 1'b1, 0);
        drain_a("drain_after_rst", 60);
        chk("pkt_after_rst", 32'(pkt_count_a), 32'(1));

        // One-beat packets with a 4-bit packet counter.
        for (int i = 0; i < 17; i++) begin
            src_b[loaded_b] = 8'(8'h20 + i);
            loaded_b++;
        end
        ifb.m_ready = 1'b1;
        rst_b = 1'b0;
        k = 0;
        while ((read_b != loaded_b || exp_b.size() != 0) && k < 60) begin
            cyc(1);
            k++;
        end
        chk("b_beats", 32'(hs_b), 32'(17));
        chk("b_pkt_wrap", 32'(pkt_count_b), 32'(1));

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
